// File: rtl/imsic_intfile_bank_if.sv
// CSR-window, MSI and claim bus between the per-hart CSR front end and the IMSIC interrupt-file bank.
interface imsic_intfile_bank_if #(
    parameter int XLEN = 64,
    parameter int FW   = 3,
    parameter int IDW  = 11
);
    logic            csr_vld;
    logic            csr_we;
    logic [FW-1:0]   csr_file;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_rdata_vld;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            msi_vld;
    logic [FW-1:0]   msi_file;
    logic [IDW-1:0]  msi_id;
    logic            claim_vld;
    logic [FW-1:0]   claim_file;

    modport master (
        output csr_vld, csr_we, csr_file, csr_addr, csr_wdata,
        output msi_vld, msi_file, msi_id, claim_vld, claim_file,
        input  csr_rdata_vld, csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_vld, csr_we, csr_file, csr_addr, csr_wdata,
        input  msi_vld, msi_file, msi_id, claim_vld, claim_file,
        output csr_rdata_vld, csr_rdata, csr_illegal
    );
endinterface

// File: rtl/imsic_intfile_bank.sv
// IMSIC interrupt-file bank: per-file eidelivery/eithreshold/eip/eie storage, MSI set, topei claim,
// and a word-serial scanner that refreshes each file's top identity in turn.
module imsic_intfile_bank #(
    parameter int NR_FILES = 7,
    parameter int NR_SRC   = 256,
    parameter int XLEN     = 64,
    parameter int FW       = 3,
    parameter int IDW      = 11
) (
    input  logic                       clk,
    input  logic                       rstn,
    imsic_intfile_bank_if.slave        bus,
    output logic [NR_FILES*IDW-1:0]    o_topei,
    output logic [NR_FILES-1:0]        o_irq
);
    localparam int NR_REG = NR_SRC / XLEN;
    localparam int LW     = $clog2(XLEN);
    localparam int RW     = (NR_REG > 1) ? $clog2(NR_REG) : 1;
    localparam logic [FW:0]  NF_L   = (FW+1)'(NR_FILES);
    localparam logic [IDW:0] NS_L   = (IDW+1)'(NR_SRC);
    localparam logic [6:0]   NREG_L = 7'(NR_REG);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} scan_state_e;

    logic            eidelivery_q  [NR_FILES], eidelivery_d  [NR_FILES];
    logic [IDW-1:0]  eithreshold_q [NR_FILES], eithreshold_d [NR_FILES];
    logic [XLEN-1:0] eip_q [NR_FILES][NR_REG], eip_d [NR_FILES][NR_REG];
    logic [XLEN-1:0] eie_q [NR_FILES][NR_REG], eie_d [NR_FILES][NR_REG];
    logic [IDW-1:0]  topei_q [NR_FILES], topei_d [NR_FILES];
    logic [NR_FILES-1:0] irq_q, irq_d;
    logic            rdata_vld_q, rdata_vld_d, illegal_q, illegal_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    scan_state_e     state_q, state_d;
    logic [FW-1:0]   f_q, f_d;
    logic [RW-1:0]   r_q, r_d;
    logic [IDW-1:0]  res_q, res_d;

    logic [5:0]      csr_idx_s;
    logic            sel_deleg_s, sel_thr_s, sel_eip_s, sel_eie_s, idx_ok_s, csr_legal_s, csr_wr_s;
    logic            msi_ok_s, claim_ok_s, touch_s;
    logic [IDW-1:0]  claim_id_s, scan_thr_s, scan_base_s;
    logic [XLEN-1:0] msi_mask_s, claim_mask_s, scan_eip_s, scan_eie_s, elig_s, rd_val_s;
    logic [LW-1:0]   hit_pos_s;

    // CSR window decode; with XLEN=64 the odd eip/eie slots do not exist
    always_comb begin
        csr_idx_s   = (XLEN == 64) ? {1'b0, bus.csr_addr[5:1]} : bus.csr_addr[5:0];
        sel_deleg_s = (bus.csr_addr == 12'h070);
        sel_thr_s   = (bus.csr_addr == 12'h072);
        sel_eip_s   = (bus.csr_addr[11:6] == 6'b000010);
        sel_eie_s   = (bus.csr_addr[11:6] == 6'b000011);
        idx_ok_s    = ({1'b0, csr_idx_s} < NREG_L) && !((XLEN == 64) && bus.csr_addr[0]);
        csr_legal_s = ({1'b0, bus.csr_file} < NF_L) &&
                      (sel_deleg_s || sel_thr_s || ((sel_eip_s || sel_eie_s) && idx_ok_s));
        csr_wr_s    = bus.csr_vld && bus.csr_we && csr_legal_s;
    end

    // MSI and claim qualification; a claim acts on whatever topei currently shows
    always_comb begin
        msi_ok_s   = bus.msi_vld && ({1'b0, bus.msi_file} < NF_L) && (bus.msi_id != '0) &&
                     ({1'b0, bus.msi_id} < NS_L);
        msi_mask_s = {{(XLEN-1){1'b0}}, 1'b1} << bus.msi_id[LW-1:0];
        claim_id_s = '0;
        for (int f = 0; f < NR_FILES; f++) begin
            claim_id_s = (bus.claim_file == FW'(f)) ? topei_q[f] : claim_id_s;
        end
        claim_ok_s   = bus.claim_vld && (claim_id_s != '0);
        claim_mask_s = {{(XLEN-1){1'b0}}, 1'b1} << claim_id_s[LW-1:0];
    end

    // Register file update: CSR write, then claim clear, then MSI set so the MSI always wins
    always_comb begin
        for (int f = 0; f < NR_FILES; f++) begin
            eidelivery_d[f]  = (csr_wr_s && sel_deleg_s && (bus.csr_file == FW'(f))) ?
                               bus.csr_wdata[0] : eidelivery_q[f];
            eithreshold_d[f] = (csr_wr_s && sel_thr_s && (bus.csr_file == FW'(f))) ?
                               bus.csr_wdata[IDW-1:0] : eithreshold_q[f];
            for (int r = 0; r < NR_REG; r++) begin
                eie_d[f][r] = (csr_wr_s && sel_eie_s && (bus.csr_file == FW'(f)) && (csr_idx_s == 6'(r))) ?
                              bus.csr_wdata : eie_q[f][r];
                eip_d[f][r] = (csr_wr_s && sel_eip_s && (bus.csr_file == FW'(f)) && (csr_idx_s == 6'(r))) ?
                              bus.csr_wdata : eip_q[f][r];
                eip_d[f][r] = eip_d[f][r] &
                              ~((claim_ok_s && (bus.claim_file == FW'(f)) &&
                                 (claim_id_s[IDW-1:LW] == (IDW-LW)'(r))) ? claim_mask_s : {XLEN{1'b0}});
                eip_d[f][r] = eip_d[f][r] |
                              ((msi_ok_s && (bus.msi_file == FW'(f)) &&
                                (bus.msi_id[IDW-1:LW] == (IDW-LW)'(r))) ? msi_mask_s : {XLEN{1'b0}});
                eip_d[f][r][0] = (r == 0) ? 1'b0 : eip_d[f][r][0];
                eie_d[f][r][0] = (r == 0) ? 1'b0 : eie_d[f][r][0];
            end
        end
    end

    // Eligible bits of the word under scan and the lowest one among them
    always_comb begin
        scan_eip_s = '0;
        scan_eie_s = '0;
        scan_thr_s = '0;
        for (int f = 0; f < NR_FILES; f++) begin
            scan_thr_s = (f_q == FW'(f)) ? eithreshold_q[f] : scan_thr_s;
            for (int r = 0; r < NR_REG; r++) begin
                scan_eip_s = ((f_q == FW'(f)) && (r_q == RW'(r))) ? eip_q[f][r] : scan_eip_s;
                scan_eie_s = ((f_q == FW'(f)) && (r_q == RW'(r))) ? eie_q[f][r] : scan_eie_s;
            end
        end
        scan_base_s = IDW'(r_q) << LW;
        for (int i = 0; i < XLEN; i++) begin
            elig_s[i] = scan_eip_s[i] & scan_eie_s[i] &
                        ((scan_thr_s == '0) || ((scan_base_s | IDW'(i)) < scan_thr_s));
        end
        hit_pos_s = '0;
        for (int i = XLEN-1; i >= 0; i--) begin
            hit_pos_s = elig_s[i] ? LW'(i) : hit_pos_s;
        end
        touch_s = (csr_wr_s && (bus.csr_file == f_q)) || (msi_ok_s && (bus.msi_file == f_q)) ||
                  (claim_ok_s && (bus.claim_file == f_q));
    end

    // Scanner next state; a touch of the file under scan discards partial work and restarts it
    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        r_d     = r_q;
        res_d   = res_q;
        topei_d = topei_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_SCAN;
                r_d     = '0;
            end
            S_SCAN: begin
                if (touch_s) begin
                    r_d = '0;
                end else if (|elig_s) begin
                    res_d   = scan_base_s | IDW'(hit_pos_s);
                    state_d = S_DONE;
                end else if (r_q == RW'(NR_REG-1)) begin
                    res_d   = '0;
                    state_d = S_DONE;
                end else begin
                    r_d = r_q + RW'(1);
                end
            end
            S_DONE: begin
                if (touch_s) begin
                    state_d = S_SCAN;
                    r_d     = '0;
                end else begin
                    for (int f = 0; f < NR_FILES; f++) begin
                        topei_d[f] = (f_q == FW'(f)) ? res_q : topei_q[f];
                    end
                    f_d     = (f_q == FW'(NR_FILES-1)) ? '0 : f_q + FW'(1);
                    r_d     = '0;
                    state_d = S_SCAN;
                end
            end
            default: begin
                state_d = S_IDLE;
                r_d     = '0;
            end
        endcase
        for (int f = 0; f < NR_FILES; f++) begin
            topei_d[f] = (claim_ok_s && (bus.claim_file == FW'(f))) ? '0 : topei_d[f];
        end
    end

    // CSR read mux, completion pulse and interrupt lines
    always_comb begin
        rd_val_s = '0;
        for (int f = 0; f < NR_FILES; f++) begin
            rd_val_s = ((bus.csr_file == FW'(f)) && sel_deleg_s) ? XLEN'(eidelivery_q[f]) : rd_val_s;
            rd_val_s = ((bus.csr_file == FW'(f)) && sel_thr_s) ? XLEN'(eithreshold_q[f]) : rd_val_s;
            for (int r = 0; r < NR_REG; r++) begin
                rd_val_s = ((bus.csr_file == FW'(f)) && (csr_idx_s == 6'(r)) && sel_eip_s) ? eip_q[f][r] : rd_val_s;
                rd_val_s = ((bus.csr_file == FW'(f)) && (csr_idx_s == 6'(r)) && sel_eie_s) ? eie_q[f][r] : rd_val_s;
            end
            irq_d[f] = eidelivery_q[f] & (topei_q[f] != '0);
        end
        rdata_vld_d = bus.csr_vld;
        illegal_d   = bus.csr_vld && !csr_legal_s;
        rdata_d     = (bus.csr_vld && !bus.csr_we) ? (csr_legal_s ? rd_val_s : {XLEN{1'b0}}) : rdata_q;
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int f = 0; f < NR_FILES; f++) begin
                eidelivery_q[f]  <= 1'b0;
                eithreshold_q[f] <= '0;
                topei_q[f]       <= '0;
                for (int r = 0; r < NR_REG; r++) begin
                    eip_q[f][r] <= '0;
                    eie_q[f][r] <= '0;
                end
            end
            irq_q       <= '0;
            rdata_vld_q <= 1'b0;
            illegal_q   <= 1'b0;
            rdata_q     <= '0;
            state_q     <= S_IDLE;
            f_q         <= '0;
            r_q         <= '0;
            res_q       <= '0;
        end else begin
            eidelivery_q  <= eidelivery_d;
            eithreshold_q <= eithreshold_d;
            eip_q         <= eip_d;
            eie_q         <= eie_d;
            topei_q       <= topei_d;
            irq_q         <= irq_d;
            rdata_vld_q   <= rdata_vld_d;
            illegal_q     <= illegal_d;
            rdata_q       <= rdata_d;
            state_q       <= state_d;
            f_q           <= f_d;
            r_q           <= r_d;
            res_q         <= res_d;
        end
    end

    // Output packing
    always_comb begin
        o_topei = '0;
        for (int f = 0; f < NR_FILES; f++) begin
            o_topei[f*IDW +: IDW] = topei_q[f];
        end
    end

    assign o_irq             = irq_q;
    assign bus.csr_rdata_vld = rdata_vld_q;
    assign bus.csr_rdata     = rdata_q;
    assign bus.csr_illegal   = illegal_q;
endmodule

// File: tb/tb_imsic_intfile_bank.sv
// Randomised bench for imsic_intfile_bank against an identity-level model of every interrupt file.
module tb_imsic_intfile_bank;
    localparam int NR_FILES = 7;
    localparam int NR_SRC   = 256;
    localparam int XLEN     = 64;
    localparam int FW       = 3;
    localparam int IDW      = 11;
    localparam int NR_REG   = NR_SRC / XLEN;
    localparam int BOUND    = NR_FILES * (NR_REG + 1);

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [NR_FILES*IDW-1:0] o_topei;
    logic [NR_FILES-1:0]     o_irq;

    imsic_intfile_bank_if #(.XLEN(XLEN), .FW(FW), .IDW(IDW)) bus ();

    imsic_intfile_bank #(.NR_FILES(NR_FILES), .NR_SRC(NR_SRC), .XLEN(XLEN), .FW(FW), .IDW(IDW)) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .o_topei(o_topei), .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: one bit per identity, not per register word
    bit m_pend [NR_FILES][NR_SRC];
    bit m_en   [NR_FILES][NR_SRC];
    int m_thr  [NR_FILES];
    bit m_deliv[NR_FILES];

    logic [11:0] addr_tab [12] = '{12'h070, 12'h072, 12'h080, 12'h082, 12'h084, 12'h086,
                                   12'h0C0, 12'h0C2, 12'h0C4, 12'h0C6, 12'h081, 12'h088};

    function automatic int m_top(int f);
        for (int id = 1; id < NR_SRC; id++)
            if (m_pend[f][id] && m_en[f][id] && (m_thr[f] == 0 || id < m_thr[f])) return id;
        return 0;
    endfunction

    function automatic bit m_legal(int f, logic [11:0] a);
        int ai = int'(a);
        if (f >= NR_FILES) return 1'b0;
        if (ai == 32'h70 || ai == 32'h72) return 1'b1;
        if (ai < 32'h80 || ai > 32'hFF || (ai % 2) != 0) return 1'b0;
        return (((ai - 32'h80) % 64) / 2) < NR_REG;
    endfunction

    function automatic logic [63:0] m_read(int f, logic [11:0] a);
        logic [63:0] v = 64'h0;
        int w;
        if (!m_legal(f, a)) return 64'h0;
        if (a == 12'h070) v[0] = m_deliv[f];
        else if (a == 12'h072) v = 64'(m_thr[f]);
        else begin
            w = ((int'(a) - 32'h80) % 64) / 2;
            for (int i = 0; i < 64; i++)
                v[i] = (a < 12'h0C0) ? m_pend[f][w*64+i] : m_en[f][w*64+i];
        end
        return v;
    endfunction

    task automatic m_write(int f, logic [11:0] a, logic [63:0] d);
        int w;
        if (m_legal(f, a)) begin
            if (a == 12'h070) m_deliv[f] = d[0];
            else if (a == 12'h072) m_thr[f] = int'(d[10:0]);
            else begin
                w = ((int'(a) - 32'h80) % 64) / 2;
                for (int i = 0; i < 64; i++) begin
                    if (w*64+i != 0) begin
                        if (a < 12'h0C0) m_pend[f][w*64+i] = d[i];
                        else m_en[f][w*64+i] = d[i];
                    end
                end
            end
        end
    endtask

    task automatic m_reset();
        for (int f = 0; f < NR_FILES; f++) begin
            m_thr[f] = 0;
            m_deliv[f] = 1'b0;
            for (int id = 0; id < NR_SRC; id++) begin
                m_pend[f][id] = 1'b0;
                m_en[f][id] = 1'b0;
            end
        end
    endtask

    task automatic csr_op(input bit we, input int f, input logic [11:0] a, input logic [63:0] d,
                          output logic vld, output logic [63:0] rd, output logic ill);
        @(negedge clk);
        bus.csr_vld = 1'b1; bus.csr_we = we; bus.csr_file = FW'(f);
        bus.csr_addr = a; bus.csr_wdata = d;
        if (we) m_write(f, a, d);
        @(negedge clk);
        bus.csr_vld = 1'b0; bus.csr_we = 1'b0;
        vld = bus.csr_rdata_vld; rd = bus.csr_rdata; ill = bus.csr_illegal;
    endtask

    task automatic do_msi(input int f, input int id);
        @(negedge clk);
        bus.msi_vld = 1'b1; bus.msi_file = FW'(f); bus.msi_id = IDW'(id);
        if (f < NR_FILES && id != 0 && id < NR_SRC) m_pend[f][id] = 1'b1;
        @(negedge clk);
        bus.msi_vld = 1'b0;
    endtask

    task automatic do_claim(input int f);
        int t;
        @(negedge clk);
        bus.claim_vld = 1'b1; bus.claim_file = FW'(f);
        t = (f < NR_FILES) ? m_top(f) : 0;
        if (t != 0) m_pend[f][t] = 1'b0;
        @(negedge clk);
        bus.claim_vld = 1'b0;
    endtask

    task automatic settle();
        repeat (BOUND + 4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic v, il; logic [63:0] rd;
        logic [11:0] a [4] = '{12'h070, 12'h072, 12'h080, 12'h0C0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (o_topei !== '0) begin n_err++; $display("FAIL reset_topei got=%h exp=0", o_topei); end
        n_vec++; if (o_irq !== '0) begin n_err++; $display("FAIL reset_irq got=%h exp=0", o_irq); end
        n_vec++; if (bus.csr_rdata !== 64'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", bus.csr_rdata); end
        n_vec++; if (bus.csr_rdata_vld !== 1'b0 || bus.csr_illegal !== 1'b0) begin
            n_err++; $display("FAIL reset_flags got vld=%b ill=%b exp=0/0", bus.csr_rdata_vld, bus.csr_illegal); end
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            csr_op(1'b0, 1, a[i], 64'h0, v, rd, il);
            n_vec++;
            if (v !== 1'b1 || rd !== 64'h0 || il !== 1'b0) begin
                n_err++; $display("FAIL reset_read addr=%h got vld=%b rd=%h ill=%b exp 1/0/0", a[i], v, rd, il);
            end
        end
        @(negedge clk);
        n_vec++; if (bus.csr_rdata_vld !== 1'b0) begin n_err++; $display("FAIL vld_pulse got=%b exp=0", bus.csr_rdata_vld); end
    endtask

    task automatic test_file1();
        logic v, il; logic [63:0] rd;
        csr_op(1'b1, 1, 12'h0C0, 64'hFFFF_FFFF_FFFF_FFFE, v, rd, il);
        csr_op(1'b1, 1, 12'h070, 64'h1, v, rd, il);
        do_msi(1, 5);
        do_msi(1, 3);
        settle();
        n_vec++; if (o_topei[1*IDW +: IDW] !== 11'd3) begin n_err++; $display("FAIL f1_top got=%0d exp=3", o_topei[1*IDW +: IDW]); end
        n_vec++; if (o_irq[1] !== 1'b1) begin n_err++; $display("FAIL f1_irq got=%b exp=1", o_irq[1]); end
        do_claim(1);
        n_vec++; if (o_topei[1*IDW +: IDW] !== 11'd0) begin n_err++; $display("FAIL f1_claim got=%0d exp=0", o_topei[1*IDW +: IDW]); end
        settle();
        n_vec++; if (o_topei[1*IDW +: IDW] !== 11'd5) begin n_err++; $display("FAIL f1_rescan got=%0d exp=5", o_topei[1*IDW +: IDW]); end
    endtask

    task automatic test_threshold();
        logic v, il; logic [63:0] rd;
        csr_op(1'b1, 2, 12'h072, 64'd4, v, rd, il);
        csr_op(1'b1, 2, 12'h0C0, 64'hFFFF_FFFF_FFFF_FFFF, v, rd, il);
        do_msi(2, 9);
        settle();
        n_vec++; if (o_topei[2*IDW +: IDW] !== 11'd0) begin n_err++; $display("FAIL thr_block got=%0d exp=0", o_topei[2*IDW +: IDW]); end
        csr_op(1'b1, 2, 12'h072, 64'd0, v, rd, il);
        settle();
        n_vec++; if (o_topei[2*IDW +: IDW] !== 11'd9) begin n_err++; $display("FAIL thr_open got=%0d exp=9", o_topei[2*IDW +: IDW]); end
        n_vec++; if (o_irq[2] !== 1'b0) begin n_err++; $display("FAIL thr_irq got=%b exp=0", o_irq[2]); end
    endtask

    task automatic test_collision();
        logic v, il; logic [63:0] rd;
        csr_op(1'b1, 0, 12'h0C0, 64'hFFFF_FFFF_FFFF_FFFF, v, rd, il);
        do_msi(0, 7);
        settle();
        n_vec++; if (o_topei[0 +: IDW] !== 11'd7) begin n_err++; $display("FAIL col_pre got=%0d exp=7", o_topei[0 +: IDW]); end
        @(negedge clk);
        bus.claim_vld = 1'b1; bus.claim_file = 3'd0;
        bus.msi_vld = 1'b1; bus.msi_file = 3'd0; bus.msi_id = 11'd7;
        @(negedge clk);
        bus.claim_vld = 1'b0; bus.msi_vld = 1'b0;
        n_vec++; if (o_topei[0 +: IDW] !== 11'd0) begin n_err++; $display("FAIL col_claim got=%0d exp=0", o_topei[0 +: IDW]); end
        csr_op(1'b0, 0, 12'h080, 64'h0, v, rd, il);
        n_vec++; if (rd[7] !== 1'b1 || rd !== m_read(0, 12'h080)) begin
            n_err++; $display("FAIL col_eip got=%h exp=%h", rd, m_read(0, 12'h080)); end
        settle();
        n_vec++; if (o_topei[0 +: IDW] !== 11'd7) begin n_err++; $display("FAIL col_post got=%0d exp=7", o_topei[0 +: IDW]); end
    endtask

    task automatic test_illegal();
        logic v, il; logic [63:0] rd;
        csr_op(1'b0, 0, 12'h081, 64'h0, v, rd, il);
        n_vec++; if (il !== 1'b1 || rd !== 64'h0 || v !== 1'b1) begin n_err++; $display("FAIL ill_odd got ill=%b rd=%h vld=%b exp 1/0/1", il, rd, v); end
        csr_op(1'b0, 0, 12'(12'h080 + 2*NR_REG), 64'h0, v, rd, il);
        n_vec++; if (il !== 1'b1 || rd !== 64'h0) begin n_err++; $display("FAIL ill_range got ill=%b rd=%h exp 1/0", il, rd); end
        csr_op(1'b0, 7, 12'h070, 64'h0, v, rd, il);
        n_vec++; if (il !== 1'b1) begin n_err++; $display("FAIL ill_file got=%b exp=1", il); end
        csr_op(1'b1, 0, 12'h071, 64'hFFFF_FFFF_FFFF_FFFF, v, rd, il);
        n_vec++; if (il !== 1'b1) begin n_err++; $display("FAIL ill_wr got=%b exp=1", il); end
        csr_op(1'b0, 0, 12'h070, 64'h0, v, rd, il);
        n_vec++; if (rd !== 64'h0 || il !== 1'b0) begin n_err++; $display("FAIL ill_nochg got rd=%h ill=%b exp 0/0", rd, il); end
        csr_op(1'b1, 3, 12'h070, 64'hFFFF_FFFF_FFFF_FFFF, v, rd, il);
        csr_op(1'b0, 3, 12'h070, 64'h0, v, rd, il);
        n_vec++; if (rd !== 64'h1) begin n_err++; $display("FAIL deleg_mask got=%h exp=1", rd); end
        csr_op(1'b1, 3, 12'h072, 64'hFFFF_FFFF_FFFF_FFFF, v, rd, il);
        csr_op(1'b0, 3, 12'h072, 64'h0, v, rd, il);
        n_vec++; if (rd !== 64'h7FF) begin n_err++; $display("FAIL thr_mask got=%h exp=7ff", rd); end
        csr_op(1'b1, 3, 12'h0C0, 64'hFFFF_FFFF_FFFF_FFFF, v, rd, il);
        csr_op(1'b0, 3, 12'h0C0, 64'h0, v, rd, il);
        n_vec++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL eie0_bit0 got=%h exp=fffffffffffffffe", rd); end
    endtask

    task automatic test_random();
        logic v, il; logic [63:0] rd, d;
        int f, op, k, et;
        logic [11:0] a;
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(3, 10);
            for (int j = 0; j < k; j++) begin
                op = $urandom_range(0, 2);
                f  = $urandom_range(0, 7);
                a  = addr_tab[$urandom_range(0, 11)];
                if (op == 0) begin
                    do_msi(f, $urandom_range(0, 300));
                end else if (op == 1) begin
                    if (a == 12'h072) d = 64'($urandom_range(0, 300));
                    else if (a < 12'h0C0) d = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                    else d = {$urandom, $urandom};
                    csr_op(1'b1, f, a, d, v, rd, il);
                    n_vec++; if (il !== !m_legal(f, a)) begin n_err++; $display("FAIL rnd_wr_ill it=%0d f=%0d a=%h got=%b", it, f, a, il); end
                end else begin
                    csr_op(1'b0, f, a, 64'h0, v, rd, il);
                    n_vec++;
                    if (rd !== m_read(f, a) || il !== !m_legal(f, a) || v !== 1'b1) begin
                        n_err++; $display("FAIL rnd_rd it=%0d f=%0d a=%h got=%h/%b exp=%h/%b", it, f, a, rd, il, m_read(f, a), !m_legal(f, a));
                    end
                end
            end
            settle();
            for (int g = 0; g < NR_FILES; g++) begin
                et = m_top(g);
                n_vec++;
                if (o_topei[g*IDW +: IDW] !== IDW'(et)) begin
                    n_err++; $display("FAIL rnd_top it=%0d f=%0d got=%0d exp=%0d", it, g, o_topei[g*IDW +: IDW], et);
                end
                n_vec++;
                if (o_irq[g] !== (m_deliv[g] && et != 0)) begin
                    n_err++; $display("FAIL rnd_irq it=%0d f=%0d got=%b exp=%b", it, g, o_irq[g], (m_deliv[g] && et != 0));
                end
            end
            if ($urandom_range(0, 1) == 1) do_claim($urandom_range(0, 7));
        end
    endtask

    task automatic test_reset_midscan();
        logic v, il; logic [63:0] rd;
        csr_op(1'b1, 6, 12'h0C6, 64'hFFFF_FFFF_FFFF_FFFF, v, rd, il);
        do_msi(6, 200);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        m_reset();
        #1;
        n_vec++; if (o_topei !== '0) begin n_err++; $display("FAIL rst_mid_top got=%h exp=0", o_topei); end
        n_vec++; if (o_irq !== '0) begin n_err++; $display("FAIL rst_mid_irq got=%h exp=0", o_irq); end
        @(negedge clk);
        rstn = 1'b1;
        csr_op(1'b0, 6, 12'h086, 64'h0, v, rd, il);
        n_vec++; if (rd !== 64'h0) begin n_err++; $display("FAIL rst_mid_eip got=%h exp=0", rd); end
        csr_op(1'b0, 6, 12'h0C6, 64'h0, v, rd, il);
        n_vec++; if (rd !== 64'h0) begin n_err++; $display("FAIL rst_mid_eie got=%h exp=0", rd); end
        settle();
        n_vec++; if (o_topei !== '0) begin n_err++; $display("FAIL rst_mid_settle got=%h exp=0", o_topei); end
    endtask

    initial begin
        bus.csr_vld = 1'b0; bus.csr_we = 1'b0; bus.csr_file = '0; bus.csr_addr = '0; bus.csr_wdata = '0;
        bus.msi_vld = 1'b0; bus.msi_file = '0; bus.msi_id = '0;
        bus.claim_vld = 1'b0; bus.claim_file = '0;
        m_reset();
        test_reset();
        test_file1();
        test_threshold();
        test_collision();
        test_illegal();
        test_random();
        test_reset_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/imsic_intfile_bank.md
Name: imsic_intfile_bank

Overview:
- Parametrised IMSIC interrupt-file bank holding NR_FILES interrupt files: M, S, and NR_FILES-2 guest (VS) files.
- Each file has eidelivery, eithreshold, eip and eie registers, accessed through the AIA indirect CSR window.
- Pending bits are set by MSI setipnum writes and cleared by topei claims.
- A sequential scanner computes each file's topei one XLEN-bit word per cycle, so deep identity spaces do not need a wide combinational priority tree. The bank feeds the per-hart CSR front end and the hart interrupt lines.

Parameters:
- NR_FILES, 7, number of interrupt files; file 0 = M, 1 = S, 2.. = VS.
- NR_SRC, 256, interrupt identities per file (64..2048, multiple of XLEN); identity 0 is never valid.
- XLEN, 64, register width (32 or 64).
- FW, 3, width of file-select fields, equal to clog2(NR_FILES).
- IDW, 11, identity field width.
- Derived: NR_REG = NR_SRC/XLEN words per file.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- csr_vld  in  1  single-cycle CSR access request
- csr_we  in  1  1 = write, 0 = read
- csr_file  in  FW  target file
- csr_addr  in  12  indirect-window address (0x70, 0x72, 0x80-0xBF, 0xC0-0xFF)
- csr_wdata  in  XLEN  write data
- csr_rdata_vld  out  1  read/write completion pulse
- csr_rdata  out  XLEN  read data
- csr_illegal  out  1  access rejected; pulses with csr_rdata_vld
- msi_vld  in  1  setipnum write pulse
- msi_file  in  FW  target file of the MSI
- msi_id  in  IDW  identity to set pending
- claim_vld  in  1  topei claim (write to the file's xtopei)
- claim_file  in  FW  file being claimed
- o_topei  out  NR_FILES*IDW  per-file top identity, 0 = none
- o_irq  out  NR_FILES  per-file interrupt line

Behaviour:
- Reset values:
  - All eidelivery, eithreshold, eip and eie registers are 0.
  - o_topei = 0, o_irq = 0, csr_rdata = 0, csr_rdata_vld = 0, csr_illegal = 0.
  - Scanner is in IDLE with file pointer 0.
  - Reset may assert in any state, including mid-scan; all state returns to these values.
- CSR access:
  - Registered, 1-cycle latency. csr_rdata_vld pulses exactly one cycle after every csr_vld, for reads and writes.
  - csr_rdata holds its value when no read completes.
- Illegal accesses (csr_illegal = 1, writes have no effect, read data = 0):
  - csr_file >= NR_FILES;
  - address outside the four register groups;
  - odd eip/eie index when XLEN = 64;
  - eip/eie word index >= NR_REG.
- Register access rules:
  - eidelivery reads as bit 0 only.
  - eithreshold stores IDW bits; upper bits read as 0.
  - Bit 0 of eip0 and eie0 is hardwired 0.
  - With XLEN = 64, word index = addr[5:1].
- MSI:
  - Always accepted.
  - Dropped silently if msi_file >= NR_FILES, msi_id == 0, or msi_id >= NR_SRC.
  - Otherwise sets the eip bit at the next edge.
- Claim:
  - Clears the eip bit of the current o_topei[claim_file] and forces that o_topei to 0 at the next edge.
  - Claim with o_topei = 0 has no effect.
- Same-cycle collisions on one eip word: final value = (CSR write data, or old value) & ~claim bit | MSI bit.
  - An MSI always wins over a claim or CSR write of the same bit.
- Eligibility: a bit is eligible iff eip & eie & (eithreshold == 0 | id < eithreshold).
- Scanner FSM:
  - IDLE -> SCAN (next cycle, always).
  - SCAN: examines word r of file f each cycle. On the first word containing an eligible bit, it records the lowest eligible id and goes to DONE. If r == NR_REG-1 with no hit, it records 0 and goes to DONE.
  - DONE: writes o_topei[f], advances f cyclically (NR_FILES-1 wraps to 0), sets r = 0, returns to SCAN.
- Restart rule: any CSR write, MSI set, or claim targeting file f while file f is being scanned restarts that scan at r = 0. Its result is discarded.
- Staleness bound: o_topei of an unmodified file is refreshed within NR_FILES*(NR_REG+1) cycles.
- o_irq[f] is registered: eidelivery[f] & (o_topei[f] != 0).

Test Plan:
- Reset, then read file 1 at 0x70, 0x72, 0x80 and 0xC0 -> each returns 0 with csr_rdata_vld one cycle after csr_vld, csr_illegal = 0.
- File 1: write eie0 = 0xFFFF_FFFF_FFFF_FFFE, eidelivery = 1, then MSI id 5 and id 3 -> within bound, o_topei[1] = 3 and o_irq[1] = 1. Claim -> o_topei[1] = 0 next cycle, then rescans to 5.
- File 2: eithreshold = 4, MSI id 9 with enabled -> o_topei[2] stays 0. Set eithreshold = 0 -> o_topei[2] = 9.
- Same cycle on file 0: claim of id 7 and MSI id 7 -> eip0 bit 7 remains 1 and o_topei[0] returns to 7.
- Read address 0x81, and read 0x80 + 2*NR_REG, with XLEN = 64 -> csr_illegal = 1, rdata = 0. Write 0x71 -> illegal, no state change.
- MSI id 200 (word 3) into file 6, then assert rstn low mid-scan -> all o_topei and o_irq are 0 and eip is cleared.
